// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, count-width helper and error
// status bit layout.
package fifo_pkg;

  localparam int unsigned FIFO_B = 8;
  localparam int unsigned FIFO_W = 4;

  // Status register layout is {underflow, overflow}
  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_UDF_BIT = 1;

  typedef struct packed {
    logic underflow;
    logic overflow;
  } fifo_err_t;

  // Occupancy must represent 0..2**w inclusive
  function automatic int unsigned count_width(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// D x B storage for the FIFO: synchronous write, asynchronous read, no reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned B = FIFO_B,
  parameter int unsigned W = FIFO_W
) (
  input  logic         i_clk,
  input  logic         i_we,
  input  logic [W-1:0] i_w_addr,
  input  logic [B-1:0] i_w_data,
  input  logic [W-1:0] i_r_addr,
  output logic [B-1:0] o_r_data
);

  localparam int unsigned D = 2**W;

  logic [B-1:0] mem_q [D];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_w_addr] <= i_w_data;
    end
  end

  assign o_r_data = mem_q[i_r_addr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous show-ahead FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int unsigned B         = FIFO_B,
  parameter int unsigned W         = FIFO_W,
  parameter int unsigned AF_THRESH = 2**W - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_wr,
  input  logic [B-1:0] i_w_data,
  input  logic         i_rd,
  input  logic         i_clr_err,
  output logic [B-1:0] o_r_data,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_almost_empty,
  output logic         o_almost_full,
  output logic [W:0]   o_count,
  output logic         o_overflow,
  output logic         o_underflow
);

  localparam int unsigned D  = 2**W;
  localparam int unsigned CW = count_width(W);

  logic [W-1:0]  w_ptr_q, w_ptr_d;
  logic [W-1:0]  r_ptr_q, r_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  fifo_err_t     err_q, err_d;
  logic          wr_acc, rd_acc, mem_we;

  // A write into a full FIFO is only legal when a pop frees the head slot
  always_comb begin
    wr_acc          = i_wr & (~full_q | i_rd);
    rd_acc          = i_rd & ~empty_q;
    mem_we          = wr_acc & ~i_reset;
    w_ptr_d         = w_ptr_q + W'(wr_acc);
    r_ptr_d         = r_ptr_q + W'(rd_acc);
    count_d         = count_q + CW'(wr_acc) - CW'(rd_acc);
    empty_d         = (count_d == '0);
    full_d          = (count_d == CW'(D));
    ae_d            = (count_d <= CW'(AE_THRESH));
    af_d            = (count_d >= CW'(AF_THRESH));
    err_d.overflow  = (i_wr & ~wr_acc) | (err_q.overflow  & ~i_clr_err);
    err_d.underflow = (i_rd & ~rd_acc) | (err_q.underflow & ~i_clr_err);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= (AF_THRESH == 0);
      err_q   <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      err_q   <= err_d;
    end
  end

  fifo_regfile #(
    .B (B),
    .W (W)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_we     (mem_we),
    .i_w_addr (w_ptr_q),
    .i_w_data (i_w_data),
    .i_r_addr (r_ptr_q),
    .o_r_data (o_r_data)
  );

  assign o_empty        = empty_q;
  assign o_full         = full_q;
  assign o_almost_empty = ae_q;
  assign o_almost_full  = af_q;
  assign o_count        = count_q;
  assign o_overflow     = err_q[ERR_OVF_BIT];
  assign o_underflow    = err_q[ERR_UDF_BIT];

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level: a reference queue scoreboards every pop and
// every flag; a second instance covers the AF=D / AE=0 threshold corners.
module tb_fifo_level;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       rd;
  logic       clr;
  logic [7:0] wdata;

  logic [7:0] a_rdata, t_rdata;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic       t_empty, t_full, t_ae, t_af, t_ovf, t_udf;
  logic [4:0] a_count, t_count;

  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_udf;
  int         total = 0;
  int         bad   = 0;
  int         n_wr  = 0;

  always #5 clk = ~clk;

  fifo_level #(.B(8), .W(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_w_data(wdata), .i_rd(rd),
    .i_clr_err(clr), .o_r_data(a_rdata), .o_empty(a_empty), .o_full(a_full),
    .o_almost_empty(a_ae), .o_almost_full(a_af), .o_count(a_count),
    .o_overflow(a_ovf), .o_underflow(a_udf)
  );

  fifo_level #(.B(8), .W(4), .AF_THRESH(16), .AE_THRESH(0)) dut_t (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_w_data(wdata), .i_rd(rd),
    .i_clr_err(clr), .o_r_data(t_rdata), .o_empty(t_empty), .o_full(t_full),
    .o_almost_empty(t_ae), .o_almost_full(t_af), .o_count(t_count),
    .o_overflow(t_ovf), .o_underflow(t_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",     32'(a_count), 32'(n));
    chk("empty",     32'(a_empty), 32'(n == 0));
    chk("full",      32'(a_full),  32'(n == D));
    chk("almost_e",  32'(a_ae),    32'(n <= 2));
    chk("almost_f",  32'(a_af),    32'(n >= 14));
    chk("overflow",  32'(a_ovf),   32'(m_ovf));
    chk("underflow", 32'(a_udf),   32'(m_udf));
    if (n != 0) chk("head", 32'(a_rdata), 32'(q[0]));
    chk("t_count",    32'(t_count), 32'(n));
    chk("t_almost_f", 32'(t_af),    32'(n >= 16));
    chk("t_almost_e", 32'(t_ae),    32'(n == 0));
    chk("t_full",     32'(t_full),  32'(n == D));
    chk("t_empty",    32'(t_empty), 32'(n == 0));
  endtask

  // One clock of stimulus; the reference queue predicts acceptance and data
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    int   n;
    logic wacc, racc;
    logic [7:0] exp_d;
    @(negedge clk);
    wr = w; wdata = d; rd = r; clr = c;
    n    = q.size();
    wacc = w && (n < D || r);
    racc = r && (n > 0);
    if (racc) begin
      #1;
      exp_d = q.pop_front();
      chk("pop_data", 32'(a_rdata), 32'(exp_d));
    end
    if (wacc) begin
      q.push_back(d);
      n_wr++;
    end
    m_ovf = (w && !wacc) || (m_ovf && !c);
    m_udf = (r && !racc) || (m_udf && !c);
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w, r;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; wdata = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    #1 check_all();

    // Fill 0x00..0x0F, then a rejected write of 0xAA
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);

    // Drain in order, then underflow, clear, clear racing a new event
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read/write while full: 0x55 must come out last
    for (int i = 0; i < 16; i++) step(1'b1, 8'(128 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous read/write while empty
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic with occupancy held in 3..13 to wrap the pointers
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      w = (q.size() < 13);
      r = ($urandom_range(0, 7) != 0) && (q.size() > 3);
      step(w, 8'($urandom), r, 1'b0);
    end
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with count=5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(192 + i), 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    check_all();
    @(negedge clk) rst = 1'b0;
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO that replaces the basic pointer/flag FIFO in the datapath. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. Simultaneous read and write are defined for every fill level. It sits between the UART receive/transmit logic and the interface/ALU side, and is the buffer used for all new byte streams.

## Interface
Parameters:
- B, 8: data word width in bits.
- W, 4: address bits; depth D = 2**W.
- AF_THRESH, 2**W-2: o_almost_full asserts when count >= AF_THRESH; legal range 1..D.
- AE_THRESH, 2: o_almost_empty asserts when count <= AE_THRESH; legal range 0..D-1.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wr  in  1  write request.
- i_w_data  in  B  write data.
- i_rd  in  1  read (pop) request.
- i_clr_err  in  1  synchronous clear of the sticky error flags.
- o_r_data  out  B  head word (show-ahead); valid while o_empty=0.
- o_empty  out  1  count==0.
- o_full  out  1  count==D.
- o_almost_empty  out  1  count<=AE_THRESH.
- o_almost_full  out  1  count>=AF_THRESH.
- o_count  out  W+1  occupancy, 0..D.
- o_overflow  out  1  sticky; set by a rejected write.
- o_underflow  out  1  sticky; set by a rejected read.

## Operation
- Storage is D x B. It is written on the clock edge at w_ptr. Reads are combinational from r_ptr (show-ahead).
- Pointers are W bits and wrap modulo D with no special case.
- Accepted write: wr_acc = i_wr & (~full | i_rd).
- Accepted read: rd_acc = i_rd & ~empty.
- Pointer update: w_ptr advances on wr_acc and r_ptr advances on rd_acc.
- Count update: count_next = count + wr_acc - rd_acc, computed in W+1 bits.
- Case rd&wr while empty: the write is accepted and the read is rejected. Count goes 0 to 1 and underflow is set.
- Case rd&wr while full: both are accepted. The head is popped, the new word lands in the freed slot, count stays D and o_full stays 1.
- Case rd&wr otherwise: both are accepted and count is unchanged.
- Write while full without read: the write is dropped, memory and pointers are unchanged, and overflow is set.
- Read while empty: nothing changes except that underflow is set.
- Error flags:
  - Each flag sets on its event and holds until i_clr_err.
  - If i_clr_err and a new error event occur in the same cycle, the flag stays set.
- All flag outputs are registers loaded from count_next. They contain no combinational path from the inputs.

## Timing
- Reset values: pointers 0, count 0, o_empty 1, o_full 0, o_almost_empty 1, o_almost_full 0 (AF_THRESH>=1), o_overflow 0, o_underflow 0.
- o_r_data is don't-care after reset. The memory is not cleared.
- Reset acts immediately, mid-operation included. Any transfer in progress that cycle is discarded.
- Write-to-read latency is 1 cycle. A word written at edge N appears on o_r_data after edge N if the FIFO was empty, and o_empty falls after edge N.
- Read: o_r_data is sampled by the consumer in the cycle i_rd=1. After that edge, o_r_data shows the next word.
- o_count and all flags update on the same edge as the transfer that changes them.

## Structure
- Shared package/header `fifo_pkg` holds:
  - the default B and W;
  - a count-width helper (W+1);
  - the error-flag bit positions, for the status register that reads {o_underflow, o_overflow}.
- One sub-module, `fifo_regfile`, holds the D x B memory: synchronous write, asynchronous read, no reset.
- Pointer, count, flag and error logic stay in fifo_level.

## Test plan
- **Reset and flags:** assert i_reset mid-stream with count=5. Required: o_count=0, o_empty=1, flags at reset values within the same cycle, and the next write/read sequence ordered from pointer 0.
- **Fill and overflow:** with B=8, W=4, write 0x00..0x0F. Required: o_full=1 and o_count=16 after the 16th edge, o_almost_full=1 from count 14. Then a 17th write of 0xAA: o_overflow=1, count stays 16, and draining returns 0x00..0x0F with no 0xAA.
- **Drain and underflow:** read 16 words from full. Required: data in order, o_almost_empty=1 from count 2, o_empty=1 after the 16th pop. Then a 17th read: o_underflow=1, count 0. Then pulse i_clr_err: both flags clear.
- **Simultaneous at boundaries:**
  - Full, with rd&wr of 0x55: count stays 16, the head is popped, and 0x55 emerges last.
  - Empty, with rd&wr of 0x33: count becomes 1, o_r_data=0x33, o_underflow=1.
- **Wrap-around:** run 40 cycles of random rd/wr with count kept between 3 and 13. Required: output matches a reference queue, and pointers wrap more than twice.
- **Thresholds:** rebuild with AF_THRESH=16 and AE_THRESH=0. Required: o_almost_full coincides with o_full, and o_almost_empty coincides with o_empty.
